// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and 3-state sequencer for the shared 4K x 16 RAM.
// Port 0 is the CPU path, port 1 the loader/IO DMA path; one access every 3 cycles.
module mem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              owner,
  output logic              memSrc,
  output logic              memDes,
  output logic [ADDR_W-1:0] AR,
  output logic [DATA_W-1:0] CB,
  input  logic [DATA_W-1:0] memData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic                last_grant;
  logic                last_grant_nx;
  logic                owner_nx;
  logic                src_nx;
  logic                des_nx;
  logic [ADDR_W-1:0]   ar_nx;
  logic [DATA_W-1:0]   cb_nx;

  logic                gnt_vld;
  logic                gnt_port;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Tie-break: fixed mode favours port 0, otherwise the port not served last.
  always_comb begin
    gnt_vld  = p0_req | p1_req;
    gnt_port = 1'b0;
    if (p0_req && p1_req) begin
      if (FIXED_PRIO != 0) gnt_port = 1'b0;
      else                 gnt_port = ~last_grant;
    end else begin
      gnt_port = p1_req;
    end
  end

  always_comb begin
    sel_we    = p0_we;
    sel_addr  = p0_addr;
    sel_wdata = p0_wdata;
    if (gnt_port) begin
      sel_we    = p1_we;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end
  end

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    owner_nx      = owner;
    src_nx        = memSrc;
    des_nx        = memDes;
    ar_nx         = AR;
    cb_nx         = CB;
    unique case (state)
      IDLE: begin
        if (gnt_vld) begin
          ar_nx         = sel_addr;
          cb_nx         = sel_wdata;
          des_nx        = sel_we;
          src_nx        = ~sel_we;
          owner_nx      = gnt_port;
          last_grant_nx = gnt_port;
          state_nx      = ACCESS;
        end
      end
      ACCESS: begin
        src_nx   = 1'b0;
        des_nx   = 1'b0;
        state_nx = RESP;
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        src_nx   = 1'b0;
        des_nx   = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      memSrc     <= 1'b0;
      memDes     <= 1'b0;
      AR         <= '0;
      CB         <= '0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      owner      <= owner_nx;
      memSrc     <= src_nx;
      memDes     <= des_nx;
      AR         <= ar_nx;
      CB         <= cb_nx;
    end
  end

  assign p0_ack = (state == RESP) && !owner;
  assign p1_ack = (state == RESP) &&  owner;
  assign busy   = (state == ACCESS) || (state == RESP);
  assign rdata  = memData;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin and fixed-priority instances, each with a RAM
// model, directed scenarios and random two-port traffic against a reference memory.
module tb_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic init_ram = 1'b1;

  always #5 CLK = ~CLK;

  logic          req   [2][2];
  logic          we    [2][2];
  logic [AW-1:0] addr  [2][2];
  logic [DW-1:0] wdata [2][2];
  logic          ack   [2][2];
  logic [DW-1:0] rdata [2];
  logic          busy  [2];
  logic          owner [2];
  logic          memSrc[2];
  logic          memDes[2];
  logic [AW-1:0] AR    [2];
  logic [DW-1:0] CB    [2];
  logic [DW-1:0] memData[2];

  logic [DW-1:0] ram    [2][4096];
  logic [DW-1:0] ref_mem[2][4096];

  int n_chk = 0;
  int n_err = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) u_dut0 (
    .CLK(CLK), .RSTn(RSTn),
    .p0_req(req[0][0]), .p0_we(we[0][0]), .p0_addr(addr[0][0]),
    .p0_wdata(wdata[0][0]), .p0_ack(ack[0][0]),
    .p1_req(req[0][1]), .p1_we(we[0][1]), .p1_addr(addr[0][1]),
    .p1_wdata(wdata[0][1]), .p1_ack(ack[0][1]),
    .rdata(rdata[0]), .busy(busy[0]), .owner(owner[0]),
    .memSrc(memSrc[0]), .memDes(memDes[0]), .AR(AR[0]), .CB(CB[0]),
    .memData(memData[0])
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) u_dut1 (
    .CLK(CLK), .RSTn(RSTn),
    .p0_req(req[1][0]), .p0_we(we[1][0]), .p0_addr(addr[1][0]),
    .p0_wdata(wdata[1][0]), .p0_ack(ack[1][0]),
    .p1_req(req[1][1]), .p1_we(we[1][1]), .p1_addr(addr[1][1]),
    .p1_wdata(wdata[1][1]), .p1_ack(ack[1][1]),
    .rdata(rdata[1]), .busy(busy[1]), .owner(owner[1]),
    .memSrc(memSrc[1]), .memDes(memDes[1]), .AR(AR[1]), .CB(CB[1]),
    .memData(memData[1])
  );

  function automatic logic [DW-1:0] seed_val(input int i);
    if (i == 16) return 16'hBEEF;
    return 16'(i * 40503) ^ 16'hA5A5;
  endfunction

  // Synchronous RAM: write and read both take effect at the edge ending the cycle.
  always @(posedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      if (init_ram) begin
        for (int i = 0; i < 4096; i++) ram[d][i] <= seed_val(i);
        memData[d] <= '0;
      end else begin
        if (memDes[d]) ram[d][AR[d]] <= CB[d];
        if (memSrc[d]) memData[d] <= ram[d][AR[d]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns after req has been dropped the cycle after ack.
  task automatic do_req(input int d, input int p, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        output int lat, output logic [DW-1:0] rd);
    logic got;
    req[d][p] = 1'b1;
    we[d][p] = w;
    addr[d][p] = a;
    wdata[d][p] = wd;
    lat = 0;
    got = 1'b0;
    rd = '0;
    while (!got && lat < 20) begin
      @(negedge CLK);
      lat++;
      if (ack[d][p]) begin
        got = 1'b1;
        rd = rdata[d];
      end
    end
    chk("ack_timeout", got, 1);
    if (got) begin
      chk("owner", owner[d], p);
      if (w) ref_mem[d][a] = wd;
      else   chk("rdata", rd, ref_mem[d][a]);
    end
    @(negedge CLK);
    req[d][p] = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(3, 0) == 0) return 12'hFFF;
    return 12'($urandom_range(15, 0));
  endfunction

  task automatic rand_port(input int d, input int p, input int n);
    int lat;
    logic [DW-1:0] rd;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(3, (d == 1 && p == 0) ? 1 : 0)) @(negedge CLK);
      do_req(d, p, 1'($urandom_range(1, 0)), pick_addr(), 16'($urandom), lat, rd);
      chk("lat_bound", lat <= 5, 1);
    end
  endtask

  // Bus monitor: every RAM access must match a live request and be followed by its ack.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic pend = 1'b0;
    logic pm0 = 1'b0;
    logic pm1 = 1'b0;
    logic m0, m1, acc;
    initial forever begin
      @(negedge CLK);
      #2;
      if (!RSTn) begin
        pend = 1'b0;
      end else begin
        acc = memSrc[g] | memDes[g];
        chk("ack_onehot", ack[g][0] & ack[g][1], 0);
        chk("busy", busy[g], acc | pend);
        if (pend) begin
          chk("ack_after_acc", (ack[g][0] & pm0) | (ack[g][1] & pm1), 1);
          chk("ctl_pulse", acc, 0);
        end else begin
          chk("ack_no_acc", ack[g][0] | ack[g][1], 0);
        end
        if (acc) begin
          m0 = req[g][0] && (we[g][0] == memDes[g]) && (addr[g][0] == AR[g])
               && (!we[g][0] || wdata[g][0] == CB[g]);
          m1 = req[g][1] && (we[g][1] == memDes[g]) && (addr[g][1] == AR[g])
               && (!we[g][1] || wdata[g][1] == CB[g]);
          chk("bus_match", m0 | m1, 1);
          chk("ctl_excl", memSrc[g] & memDes[g], 0);
          pm0 = m0;
          pm1 = m1;
        end
        pend = acc;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int l0, l1, a0, a1, cnt;
    logic [DW-1:0] r0, r1;
    int t_ack[$];
    int p_ack[$];

    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 1'b0;
        we[d][p] = 1'b0;
        addr[d][p] = '0;
        wdata[d][p] = '0;
      end
      for (int i = 0; i < 4096; i++) ref_mem[d][i] = seed_val(i);
    end

    // Reset state
    @(negedge CLK);
    init_ram = 1'b0;
    @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      chk("rst_memSrc", memSrc[d], 0);
      chk("rst_memDes", memDes[d], 0);
      chk("rst_AR", AR[d], 0);
      chk("rst_CB", CB[d], 0);
      chk("rst_ack0", ack[d][0], 0);
      chk("rst_ack1", ack[d][1], 0);
      chk("rst_busy", busy[d], 0);
      chk("rst_owner", owner[d], 0);
    end
    RSTn = 1'b1;
    @(negedge CLK);

    // Single read, minimum latency
    fork
      do_req(0, 0, 1'b0, 12'h010, 16'h0, l0, r0);
      begin
        @(negedge CLK);
        chk("t2_memSrc", memSrc[0], 1);
        chk("t2_memDes", memDes[0], 0);
        chk("t2_AR", AR[0], 12'h010);
      end
    join
    chk("t2_lat", l0, 2);
    chk("t2_rdata", r0, 16'hBEEF);

    // Write on p1 then read-back on p0, requested together
    fork
      do_req(0, 1, 1'b1, 12'h020, 16'h1234, l1, r1);
      do_req(0, 0, 1'b0, 12'h020, 16'h0, l0, r0);
      begin
        @(negedge CLK);
        chk("t3_memDes", memDes[0], 1);
        chk("t3_CB", CB[0], 16'h1234);
        chk("t3_AR", AR[0], 12'h020);
      end
    join
    chk("t3_p1_lat", l1, 2);
    chk("t3_p0_lat", l0, 5);
    chk("t3_rdata", r0, 16'h1234);
    chk("t3_ram", ram[0][12'h020], 16'h1234);

    // Both ports requesting continuously from reset
    RSTn = 1'b0;
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 12'h100;
    req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 12'h101;
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    for (int i = 1; i <= 30 && p_ack.size() < 6; i++) begin
      @(negedge CLK);
      if (ack[0][0]) begin p_ack.push_back(0); t_ack.push_back(i); end
      if (ack[0][1]) begin p_ack.push_back(1); t_ack.push_back(i); end
    end
    req[0][0] = 1'b0;
    req[0][1] = 1'b0;
    chk("t4_count", p_ack.size(), 6);
    if (t_ack.size() > 0) chk("t4_first", t_ack[0], 2);
    for (int k = 0; k < p_ack.size(); k++) begin
      chk("t4_order", p_ack[k], k % 2);
      if (k > 0) chk("t4_gap", t_ack[k] - t_ack[k-1], 3);
    end
    repeat (3) @(negedge CLK);

    // Fixed priority: port 1 waits until port 0 lets go
    req[1][0] = 1'b1; we[1][0] = 1'b0; addr[1][0] = 12'h040;
    req[1][1] = 1'b1; we[1][1] = 1'b0; addr[1][1] = 12'h041;
    a0 = 0;
    a1 = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge CLK);
      a0 += int'(ack[1][0]);
      a1 += int'(ack[1][1]);
    end
    req[1][0] = 1'b0;
    chk("t5_p0_acks", a0, 3);
    chk("t5_p1_acks", a1, 0);
    cnt = 0;
    r1 = '0;
    a1 = 0;
    while (a1 == 0 && cnt < 8) begin
      @(negedge CLK);
      cnt++;
      if (ack[1][1]) begin a1 = 1; r1 = rdata[1]; end
    end
    chk("t5_p1_wait", cnt, 2);
    chk("t5_rdata", r1, ref_mem[1][12'h041]);
    @(negedge CLK);
    req[1][1] = 1'b0;
    repeat (2) @(negedge CLK);

    // Reset landing on the edge that ends ACCESS of a p1 write
    req[0][1] = 1'b1; we[0][1] = 1'b1; addr[0][1] = 12'h030;
    wdata[0][1] = 16'h5555;
    @(negedge CLK);
    chk("t6_memDes", memDes[0], 1);
    RSTn = 1'b0;
    @(negedge CLK);
    req[0][1] = 1'b0;
    chk("t6_memDes_clr", memDes[0], 0);
    chk("t6_memSrc_clr", memSrc[0], 0);
    chk("t6_busy", busy[0], 0);
    chk("t6_ack1", ack[0][1], 0);
    chk("t6_ram", ram[0][12'h030], 16'h5555);
    ref_mem[0][12'h030] = 16'h5555;
    @(negedge CLK);
    RSTn = 1'b1;
    a1 = 0;
    repeat (5) begin
      @(negedge CLK);
      a1 += int'(ack[0][1]);
    end
    chk("t6_no_ack", a1, 0);
    chk("t6_idle", busy[0], 0);

    // Random traffic on both instances
    fork
      rand_port(0, 0, 30);
      rand_port(0, 1, 30);
      rand_port(1, 0, 30);
      rand_port(1, 1, 30);
    join
    repeat (3) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
